// File: rtl/seq_uart_tx.sv
// Streams every remaining word of a sequential source out as async serial frames (start, W data LSB first, stop).
// Optional feature: define SEQ_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module seq_uart_tx #(
    parameter int unsigned W   = 8,
    parameter int unsigned DIV = 868
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    output logic         src_get,
    input  logic [W-1:0] src_data,
    input  logic         src_empty,
    output logic         txd,
    output logic         busy,
    output logic         done
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BW = $clog2(W + 1);

`ifdef SEQ_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;
`endif

    state_t        state, state_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [CW-1:0] div_q, div_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          txd_d;
    logic          finish_q, finish_d;
    logic          div_last;
`ifdef SEQ_UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    assign div_last = (div_q == CW'(DIV - 1));
    assign busy     = (state != IDLE);
    // Gated by src_empty so a stray strobe can never stall the source.
    assign src_get  = (state == FETCH) && !src_empty;

    // State, datapath and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            shift_q  <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            txd      <= 1'b1;
            finish_q <= 1'b0;
            done     <= 1'b0;
`ifdef SEQ_UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            shift_q  <= shift_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            txd      <= txd_d;
            finish_q <= finish_d;
            done     <= finish_q;
`ifdef SEQ_UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    // Next state; txd and done lag the state by one register so the line edge follows the decision
    always_comb begin
        state_d  = state;
        shift_d  = shift_q;
        div_d    = div_q;
        bit_d    = bit_q;
        txd_d    = 1'b1;
        finish_d = 1'b0;
`ifdef SEQ_UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    if (src_empty) finish_d = 1'b1;
                    else           state_d  = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                shift_d = src_data;
`ifdef SEQ_UART_TX_PARITY_EN
                par_d   = ^src_data;
`endif
                div_d   = '0;
                bit_d   = '0;
                state_d = START;
            end
            START: begin
                txd_d = 1'b0;
                div_d = div_q + CW'(1);
                if (div_last) begin
                    div_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                txd_d = shift_q[0];
                div_d = div_q + CW'(1);
                if (div_last) begin
                    div_d   = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BW'(W - 1)) begin
                        bit_d   = '0;
`ifdef SEQ_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef SEQ_UART_TX_PARITY_EN
            PARITY: begin
                txd_d = par_q;
                div_d = div_q + CW'(1);
                if (div_last) begin
                    div_d   = '0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                txd_d = 1'b1;
                div_d = div_q + CW'(1);
                if (div_last) begin
                    div_d = '0;
                    if (src_empty) begin
                        state_d  = IDLE;
                        finish_d = 1'b1;
                    end else begin
                        state_d  = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_seq_uart_tx.sv
// Bench for seq_uart_tx: four instances (DIV 4, 2, 3, 17) each fed by a sequential source model,
// directed timing table plus randomized contents decoded by a behavioural UART receiver.
module tb_seq_uart_tx;
    localparam int W    = 8;
    localparam int NDUT = 4;
`ifdef SEQ_UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         start_v [NDUT];
    logic         get_v   [NDUT];
    logic [W-1:0] data_v  [NDUT];
    logic         empty_v [NDUT];
    logic         txd_v   [NDUT];
    logic         busy_v  [NDUT];
    logic         done_v  [NDUT];

    logic [7:0]   mem [NDUT][16];
    int           n_words [NDUT];
    int           ptr [NDUT];
    logic         rewind [NDUT];
    int           get_cnt  [NDUT] = '{0, 0, 0, 0};
    int           done_cnt [NDUT] = '{0, 0, 0, 0};
    int           bad_get  [NDUT] = '{0, 0, 0, 0};
    int           divs [NDUT] = '{4, 2, 3, 17};

    int           checks   = 0;
    int           failures = 0;
    bit           tr_txd[$], tr_busy[$], tr_get[$], tr_done[$];
    logic [7:0]   rx_q[$];

    typedef struct { int t; logic [3:0] exp; } vec_t;   // exp = {txd, busy, src_get, done}
    vec_t         vtab[$];

    always #5 clock = ~clock;

    seq_uart_tx #(.W(W), .DIV(4)) u_dut0 (
        .clock(clock), .reset(reset), .start(start_v[0]), .src_get(get_v[0]), .src_data(data_v[0]),
        .src_empty(empty_v[0]), .txd(txd_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    seq_uart_tx #(.W(W), .DIV(2)) u_dut1 (
        .clock(clock), .reset(reset), .start(start_v[1]), .src_get(get_v[1]), .src_data(data_v[1]),
        .src_empty(empty_v[1]), .txd(txd_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    seq_uart_tx #(.W(W), .DIV(3)) u_dut2 (
        .clock(clock), .reset(reset), .start(start_v[2]), .src_get(get_v[2]), .src_data(data_v[2]),
        .src_empty(empty_v[2]), .txd(txd_v[2]), .busy(busy_v[2]), .done(done_v[2]));
    seq_uart_tx #(.W(W), .DIV(17)) u_dut3 (
        .clock(clock), .reset(reset), .start(start_v[3]), .src_get(get_v[3]), .src_data(data_v[3]),
        .src_empty(empty_v[3]), .txd(txd_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    // Sequential ROM model: word valid the cycle after get; reads while empty are ignored
    always @(posedge clock) begin
        for (int i = 0; i < NDUT; i++) begin
            if (rewind[i]) ptr[i] <= 0;
            else if (get_v[i] && !empty_v[i]) begin
                data_v[i] <= mem[i][ptr[i][3:0]];
                ptr[i]    <= ptr[i] + 1;
            end
            if (get_v[i])               get_cnt[i]  <= get_cnt[i] + 1;
            if (get_v[i] && empty_v[i]) bad_get[i]  <= bad_get[i] + 1;
            if (done_v[i])              done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < NDUT; i++) empty_v[i] = (ptr[i] >= n_words[i]);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void addv(input int t, input logic [3:0] e);
        vec_t v;
        v.t = t;
        v.exp = e;
        vtab.push_back(v);
    endfunction

    task automatic rewind_src(input int k, input int n);
        n_words[k] = n;
        @(posedge clock); #1 rewind[k] = 1'b1;
        @(posedge clock); #1 rewind[k] = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    // Start is sampled at the second posedge (edge n); trace sample t is taken at the negedge after edge n+t
    task automatic pulse_start(input int k, input bit hold);
        @(posedge clock); #1 start_v[k] = 1'b1;
        @(posedge clock);
        if (!hold) #1 start_v[k] = 1'b0;
    endtask

    task automatic rec(input int k, input int ncyc);
        tr_txd.delete(); tr_busy.delete(); tr_get.delete(); tr_done.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clock);
            tr_txd.push_back(txd_v[k]);
            tr_busy.push_back(busy_v[k]);
            tr_get.push_back(get_v[k]);
            tr_done.push_back(done_v[k]);
        end
    endtask

    // Behavioural receiver: find a low level, then sample the middle of each bit period
    task automatic decode(input int div, output int nfr, output bit err);
        int i;
        int stop_off;
        logic [W-1:0] b;
        rx_q.delete();
        nfr = 0;
        err = 1'b0;
        i = 0;
        stop_off = (W + 1 + PB) * div + div / 2;
        while (i < tr_txd.size()) begin
            if (tr_txd[i] == 1'b0) begin
                if (i + stop_off >= tr_txd.size()) begin
                    err = 1'b1;
                    break;
                end
                if (tr_txd[i + div / 2] != 1'b0) err = 1'b1;
                for (int j = 0; j < W; j++) b[j] = tr_txd[i + (j + 1) * div + div / 2];
                if (PB == 1 && int'(tr_txd[i + (W + 1) * div + div / 2]) != ($countones(b) % 2)) err = 1'b1;
                if (tr_txd[i + stop_off] != 1'b1) err = 1'b1;
                rx_q.push_back(b);
                nfr++;
                i = i + stop_off + 1;
            end else begin
                i++;
            end
        end
    endtask

    function automatic int count_ones(input bit q[$]);
        int s = 0;
        foreach (q[i]) s += int'(q[i]);
        return s;
    endfunction

    initial begin
        int g0, d0, g1, nfr, nb, f, act, bad;
        bit err;
        logic [7:0] exp_b [16];

        reset = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            start_v[i] = 1'b0;
            rewind[i]  = 1'b1;
            n_words[i] = 0;
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < NDUT; i++) rewind[i] = 1'b0;

        // Reset state
        @(negedge clock);
        chk("reset txd", int'(txd_v[0]), 1);
        chk("reset busy", int'(busy_v[0]), 0);
        chk("reset done", int'(done_v[0]), 0);
        chk("reset src_get", int'(get_v[0]), 0);
        act = 0;
        for (int i = 1; i < NDUT; i++) act += int'(!txd_v[i]) + int'(busy_v[i]) + int'(done_v[i]) + int'(get_v[i]);
        chk("reset others", act, 0);

        // Two words 0x55, 0xA3 at DIV=4: cycle-exact trace table
        f = (W + 2 + PB) * 4;
        mem[0][0] = 8'h55;
        mem[0][1] = 8'hA3;
        rewind_src(0, 2);
        g0 = get_cnt[0];
        d0 = done_cnt[0];
        addv(0, 4'b1110);     addv(1, 4'b1100);     addv(2, 4'b1100);     addv(3, 4'b0100);
        addv(6, 4'b0100);     addv(7, 4'b1100);     addv(11, 4'b0100);    addv(35, 4'b0100);
        addv(2 + f, 4'b1110); addv(3 + f, 4'b1100); addv(4 + f, 4'b1100); addv(5 + f, 4'b0100);
        addv(9 + f, 4'b1100); addv(17 + f, 4'b0100); addv(29 + f, 4'b1100);
        addv(4 + 2 * f, 4'b1000); addv(5 + 2 * f, 4'b1001); addv(6 + 2 * f, 4'b1000);
        pulse_start(0, 1'b0);
        rec(0, 10 + 2 * f);
        foreach (vtab[i]) begin
            act = int'({tr_txd[vtab[i].t], tr_busy[vtab[i].t], tr_get[vtab[i].t], tr_done[vtab[i].t]});
            chk($sformatf("trace t=%0d", vtab[i].t), act, int'(vtab[i].exp));
        end
        decode(4, nfr, err);
        chk("two-word frames", nfr, 2);
        chk("two-word byte0", int'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 8'h55);
        chk("two-word byte1", int'(rx_q.size() > 1 ? rx_q[1] : 8'h00), 8'hA3);
        chk("two-word framing", int'(err), 0);
        chk("two-word gets", get_cnt[0] - g0, 2);
        chk("two-word dones", done_cnt[0] - d0, 1);

        // Start with an exhausted source: immediate done, nothing else moves
        g0 = get_cnt[0];
        d0 = done_cnt[0];
        pulse_start(0, 1'b0);
        rec(0, 6);
        chk("empty gets", get_cnt[0] - g0, 0);
        chk("empty busy", count_ones(tr_busy), 0);
        chk("empty txd high", count_ones(tr_txd), 6);
        chk("empty done t0", int'(tr_done[0]), 0);
        chk("empty done t1", int'(tr_done[1]), 1);
        chk("empty dones", done_cnt[0] - d0, 1);

        // Start held through a three-word drain
        mem[0][0] = 8'h07;
        mem[0][1] = 8'hC4;
        mem[0][2] = 8'h5A;
        rewind_src(0, 3);
        g0 = get_cnt[0];
        pulse_start(0, 1'b1);
        rec(0, 3 * (f + 2) + 12);
        start_v[0] = 1'b0;
        decode(4, nfr, err);
        chk("held frames", nfr, 3);
        chk("held byte0", int'(rx_q.size() > 0 ? rx_q[0] : 8'h00), 8'h07);
        chk("held byte2", int'(rx_q.size() > 2 ? rx_q[2] : 8'h00), 8'h5A);
        chk("held framing", int'(err), 0);
        chk("held gets", get_cnt[0] - g0, 3);
        chk("held busy end", int'(tr_busy[tr_busy.size() - 1]), 0);
`ifdef SEQ_UART_TX_PARITY_EN
        chk("parity of 0x07", int'(tr_txd[3 + 4 * (W + 1) + 1]), 1);
        chk("parity of 0xC4", int'(tr_txd[5 + f + 4 * (W + 1) + 1]), 1);
`endif
        repeat (4) @(posedge clock);

        // Reset while the second word is in its data bits
        mem[0][0] = 8'h11;
        mem[0][1] = 8'h22;
        mem[0][2] = 8'h33;
        rewind_src(0, 3);
        d0 = done_cnt[0];
        pulse_start(0, 1'b0);
        rec(0, 16 + f);
        chk("pre-reset busy", int'(tr_busy[15 + f]), 1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("mid-reset txd", int'(txd_v[0]), 1);
        chk("mid-reset busy", int'(busy_v[0]), 0);
        reset = 1'b0;
        g1 = get_cnt[0];
        rec(0, 30);
        chk("post-reset gets", get_cnt[0] - g1, 0);
        chk("post-reset txd high", count_ones(tr_txd), 30);
        chk("post-reset busy", count_ones(tr_busy), 0);
        chk("post-reset dones", done_cnt[0] - d0, 0);

        // Random contents on every divider
        for (int k = 0; k < NDUT; k++) begin
            for (int r = 0; r < 2; r++) begin
                nb = int'($urandom_range(2, 6));
                for (int j = 0; j < nb; j++) begin
                    exp_b[j]  = 8'($urandom);
                    mem[k][j] = exp_b[j];
                end
                rewind_src(k, nb);
                g0 = get_cnt[k];
                d0 = done_cnt[k];
                f  = (W + 2 + PB) * divs[k];
                pulse_start(k, 1'b0);
                rec(k, nb * (f + 2) + 10);
                decode(divs[k], nfr, err);
                chk($sformatf("rand div%0d frames", divs[k]), nfr, nb);
                for (int j = 0; j < nb; j++)
                    chk($sformatf("rand div%0d byte%0d", divs[k], j),
                        int'(rx_q.size() > j ? rx_q[j] : 8'h00), int'(exp_b[j]));
                chk($sformatf("rand div%0d framing", divs[k]), int'(err), 0);
                chk($sformatf("rand div%0d gets", divs[k]), get_cnt[k] - g0, nb);
                chk($sformatf("rand div%0d dones", divs[k]), done_cnt[k] - d0, 1);
            end
        end

        bad = 0;
        for (int i = 0; i < NDUT; i++) bad += bad_get[i];
        chk("get while empty", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
